// File: rtl/conv_stream_arbiter.sv
// conv_stream_arbiter: round-robin burst arbiter merging NREQ engine streams onto one registered AXI-Stream output
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   IN_AXIS_TDATA   packed per-requester data, requester i at [i*OUTW +: OUTW]
//   IN_AXIS_TVALID  per-requester valid
//   IN_AXIS_TREADY  per-requester ready, only the granted bit can be high
//   OUT_AXIS_TDATA  registered output data
//   OUT_AXIS_TID    registered index of the requester that sourced the beat
//   OUT_AXIS_TVALID registered output valid
//   OUT_AXIS_TREADY sink ready
//   BUSY            high while a requester holds the grant
// Define CONV_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module conv_stream_arbiter #(
  parameter int OUTW = 24,
  parameter int NREQ = 4,
  parameter int BURST = 8,
  localparam int IDW = $clog2(NREQ),
  localparam int CNTW = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ*OUTW-1:0] IN_AXIS_TDATA,
  input  logic [NREQ-1:0]      IN_AXIS_TVALID,
  output logic [NREQ-1:0]      IN_AXIS_TREADY,
  output logic [OUTW-1:0]      OUT_AXIS_TDATA,
  output logic [IDW-1:0]       OUT_AXIS_TID,
  output logic                 OUT_AXIS_TVALID,
  input  logic                 OUT_AXIS_TREADY,
  output logic                 BUSY
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IDW-1:0] grant, last_grant, winner;
  logic [CNTW-1:0] beat_cnt;
  logic stage_rdy, accept;
  // The output register has no skid buffer, so sink ready feeds straight back to the granted requester.
  assign stage_rdy = !OUT_AXIS_TVALID || OUT_AXIS_TREADY;
  assign accept = state == GRANT && IN_AXIS_TVALID[grant] && stage_rdy;
  assign BUSY = state == GRANT;
  always_comb IN_AXIS_TREADY = (state == GRANT && stage_rdy) ? NREQ'(1) << grant : '0;
  // Scan from the far end so the candidate closest to the search start is written last and wins.
  always_comb begin
    winner = '0;
`ifdef CONV_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--)
      if (IN_AXIS_TVALID[i]) winner = IDW'(i);
`else
    for (int k = NREQ; k >= 1; k--)
      if (IN_AXIS_TVALID[(int'(last_grant) + k) % NREQ]) winner = IDW'((int'(last_grant) + k) % NREQ);
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IDW'(NREQ - 1);
      beat_cnt <= '0;
      OUT_AXIS_TDATA <= '0;
      OUT_AXIS_TID <= '0;
      OUT_AXIS_TVALID <= 1'b0;
    end else begin
      if (accept) begin
        OUT_AXIS_TDATA <= IN_AXIS_TDATA[int'(grant)*OUTW +: OUTW];
        OUT_AXIS_TID <= grant;
        OUT_AXIS_TVALID <= 1'b1;
      end else if (OUT_AXIS_TREADY) begin
        OUT_AXIS_TVALID <= 1'b0;
      end
      if (state == IDLE) begin
        if (|IN_AXIS_TVALID) begin
          state <= GRANT;
          grant <= winner;
          beat_cnt <= '0;
        end
      // Release on a full burst, or on an empty source only when the stage could have taken a beat.
      end else if ((accept && beat_cnt == CNTW'(BURST - 1)) || (!IN_AXIS_TVALID[grant] && stage_rdy)) begin
        state <= IDLE;
        last_grant <= grant;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_arbiter.sv
// tb_conv_stream_arbiter: self-checking bench for conv_stream_arbiter
module tb_conv_stream_arbiter;
  localparam int OUTW = 24;
  localparam int NREQ = 4;
  localparam int BURST = 4;
  localparam int IDW = $clog2(NREQ);
`ifdef CONV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [NREQ*OUTW-1:0] in_tdata;
  logic [NREQ-1:0] in_tvalid, in_tready;
  logic [OUTW-1:0] out_tdata;
  logic [IDW-1:0] out_tid;
  logic out_tvalid, out_tready, busy;
  conv_stream_arbiter #(.OUTW(OUTW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk(clk),
    .reset(reset),
    .IN_AXIS_TDATA(in_tdata),
    .IN_AXIS_TVALID(in_tvalid),
    .IN_AXIS_TREADY(in_tready),
    .OUT_AXIS_TDATA(out_tdata),
    .OUT_AXIS_TID(out_tid),
    .OUT_AXIS_TVALID(out_tvalid),
    .OUT_AXIS_TREADY(out_tready),
    .BUSY(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [OUTW-1:0] d;
    int t;
    int c;
  } beat_t;
  logic [OUTW-1:0] q[NREQ][$];
  logic [OUTW-1:0] exp_q[NREQ][$];
  bit en[NREQ];
  bit sink;
  beat_t obs[$];
  bit busy_q[$];
  int cyc, checks, failures;
  function automatic logic [OUTW-1:0] mk(int i, int n);
    return OUTW'((i << 16) | (n + 1));
  endfunction
  task automatic load(int i, int n);
    for (int k = 0; k < n; k++) q[i].push_back(mk(i, k));
  endtask
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      in_tvalid[i] = en[i] && q[i].size() > 0;
      in_tdata[i*OUTW +: OUTW] = q[i].size() > 0 ? q[i][0] : '0;
    end
    out_tready = sink;
  endtask
  task automatic tick();
    logic [NREQ-1:0] acc;
    beat_t b;
    drive();
    #1;
    acc = in_tvalid & in_tready;
    if (out_tvalid && out_tready) begin
      b.d = out_tdata;
      b.t = int'(out_tid);
      b.c = cyc;
      obs.push_back(b);
    end
    busy_q.push_back(busy);
    checks++;
    if ($countones(in_tready) > 1) begin
      failures++;
      $display("FAIL tready_onehot cyc=%0d got=%b required=at most one bit", cyc, in_tready);
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(q[i].pop_front());
  endtask
  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      en[i] = 1'b0;
    end
    sink = 1'b1;
    obs.delete();
    busy_q.delete();
    cyc = 0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    clear_all();
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    clear_all();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 2);
      en[i] = 1'b1;
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    checks += 5;
    if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b required=0", out_tvalid); end
    if (out_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h required=0", out_tdata); end
    if (out_tid !== '0) begin failures++; $display("FAIL reset_tid got=%0d required=0", out_tid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (in_tready !== '0) begin failures++; $display("FAIL reset_tready got=%b required=0", in_tready); end
  endtask
  task automatic test_single();
    do_reset();
    for (int n = 0; n < BURST; n++) q[2].push_back(OUTW'(n + 1));
    en[2] = 1'b1;
    repeat (BURST + 5) tick();
    checks += 4;
    if (busy_q[0] !== 1'b0) begin failures++; $display("FAIL single_busy0 got=%b required=0", busy_q[0]); end
    if (busy_q[1] !== 1'b1) begin failures++; $display("FAIL single_busy1 got=%b required=1", busy_q[1]); end
    if (busy_q[BURST+1] !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b required=0", busy_q[BURST+1]); end
    if (obs.size() != BURST) begin failures++; $display("FAIL single_count got=%0d required=%0d", obs.size(), BURST); end
    for (int k = 0; k < BURST && k < obs.size(); k++) begin
      checks++;
      if (obs[k].d !== OUTW'(k + 1) || obs[k].t != 2 || obs[k].c != 2 + k) begin
        failures++;
        $display("FAIL single_beat%0d got=%h/%0d@%0d required=%h/2@%0d", k, obs[k].d, obs[k].t, obs[k].c, OUTW'(k + 1), 2 + k);
      end
    end
  endtask
  task automatic test_pairs();
    for (int p = 0; p < 2; p++) begin
      int b, et, ec, idx;
      int seq[NREQ];
      logic [OUTW-1:0] ed;
      b = p == 0 ? 1 : 3;
      for (int i = 0; i < NREQ; i++) seq[i] = 0;
      do_reset();
      load(0, 3 * BURST);
      load(b, 3 * BURST);
      en[0] = 1'b1;
      en[b] = 1'b1;
      repeat (3 * BURST + 6) tick();
      checks++;
      if (obs.size() < 3 * BURST) begin failures++; $display("FAIL pair%0d_count got=%0d required>=%0d", b, obs.size(), 3 * BURST); end
      for (int g = 0; g < 3; g++)
        for (int k = 0; k < BURST; k++) begin
          idx = g * BURST + k;
          et = FIXED ? 0 : (g % 2 == 1 ? b : 0);
          ed = mk(et, seq[et]);
          seq[et]++;
          ec = 2 + g * (BURST + 1) + k;
          if (idx < obs.size()) begin
            checks++;
            if (obs[idx].d !== ed || obs[idx].t != et || obs[idx].c != ec) begin
              failures++;
              $display("FAIL pair%0d_beat%0d got=%h/%0d@%0d required=%h/%0d@%0d", b, idx, obs[idx].d, obs[idx].t, obs[idx].c, ed, et, ec);
            end
          end
        end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    load(3, BURST);
    en[3] = 1'b1;
    repeat (2) tick();
    sink = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== mk(3, 0) || out_tid !== IDW'(3) || in_tready[3] !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d got=v%b %h/%0d rdy%b required=v1 %h/3 rdy0", s, out_tvalid, out_tdata, out_tid, in_tready[3], mk(3, 0));
      end
    end
    sink = 1'b1;
    repeat (BURST + 4) tick();
    checks++;
    if (obs.size() != BURST) begin failures++; $display("FAIL stall_count got=%0d required=%0d", obs.size(), BURST); end
    for (int k = 0; k < BURST && k < obs.size(); k++) begin
      checks++;
      if (obs[k].d !== mk(3, k) || obs[k].t != 3 || obs[k].c != (k == 0 ? 7 : 7 + k)) begin
        failures++;
        $display("FAIL stall_beat%0d got=%h/%0d@%0d required=%h/3@%0d", k, obs[k].d, obs[k].t, obs[k].c, mk(3, k), 7 + k);
      end
    end
  endtask
  task automatic test_early_release();
    int et, ec, en_k;
    do_reset();
    load(1, 3);
    load(2, BURST);
    en[1] = 1'b1;
    en[2] = 1'b1;
    repeat (BURST + 10) tick();
    checks += 3;
    if (busy_q[4] !== 1'b1) begin failures++; $display("FAIL early_busy4 got=%b required=1", busy_q[4]); end
    if (busy_q[5] !== 1'b0) begin failures++; $display("FAIL early_busy5 got=%b required=0", busy_q[5]); end
    if (obs.size() != 3 + BURST) begin failures++; $display("FAIL early_count got=%0d required=%0d", obs.size(), 3 + BURST); end
    for (int k = 0; k < 3 + BURST && k < obs.size(); k++) begin
      et = k < 3 ? 1 : 2;
      en_k = k < 3 ? k : k - 3;
      ec = k < 3 ? 2 + k : 7 + en_k;
      checks++;
      if (obs[k].d !== mk(et, en_k) || obs[k].t != et || obs[k].c != ec) begin
        failures++;
        $display("FAIL early_beat%0d got=%h/%0d@%0d required=%h/%0d@%0d", k, obs[k].d, obs[k].t, obs[k].c, mk(et, en_k), et, ec);
      end
    end
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    load(1, BURST);
    en[1] = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_tvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got=v%b busy%b required=v1 busy1", out_tvalid, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks += 3;
    if (out_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid got=%b required=0", out_tvalid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b required=0", busy); end
    if (in_tready !== '0) begin failures++; $display("FAIL midrst_tready got=%b required=0", in_tready); end
    clear_all();
    load(0, BURST);
    load(1, BURST);
    en[0] = 1'b1;
    en[1] = 1'b1;
    drive();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if (obs.size() == 0) begin
      failures++;
      $display("FAIL midrst_first got=none required=%h/0@2", mk(0, 0));
    end else if (obs[0].d !== mk(0, 0) || obs[0].t != 0 || obs[0].c != 2) begin
      failures++;
      $display("FAIL midrst_first got=%h/%0d@%0d required=%h/0@2", obs[0].d, obs[0].t, obs[0].c, mk(0, 0));
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      int total, n;
      logic [OUTW-1:0] v;
      total = 0;
      obs.delete();
      for (int i = 0; i < NREQ; i++) begin
        exp_q[i].delete();
        for (int k = $urandom_range(0, 3 * BURST); k > 0; k--) begin
          v = OUTW'($urandom);
          q[i].push_back(v);
          exp_q[i].push_back(v);
          total++;
        end
      end
      n = 0;
      while (obs.size() < total && n < 3000) begin
        for (int i = 0; i < NREQ; i++) en[i] = $urandom_range(0, 3) != 0;
        sink = $urandom_range(0, 2) != 0;
        tick();
        n++;
      end
      sink = 1'b1;
      repeat (3) tick();
      checks++;
      if (obs.size() != total) begin failures++; $display("FAIL rand%0d_count got=%0d required=%0d", r, obs.size(), total); end
      foreach (obs[j]) begin
        checks++;
        if (exp_q[obs[j].t].size() == 0) begin
          failures++;
          $display("FAIL rand%0d_extra got=%h/%0d required=no beat", r, obs[j].d, obs[j].t);
        end else begin
          v = exp_q[obs[j].t].pop_front();
          if (obs[j].d !== v) begin
            failures++;
            $display("FAIL rand%0d_beat%0d got=%h/%0d required=%h", r, j, obs[j].d, obs[j].t, v);
          end
        end
      end
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_pairs();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_stream_arbiter.md
# conv_stream_arbiter

Round-robin burst arbiter that merges the output streams of NREQ convolution engines, each fronted by its own output FIFO, onto one shared AXI-Stream output port. It grants one requester at a time for a burst of up to BURST beats. Data passes through a single registered output stage, and the stage reports which engine produced each beat. The block sits between the per-engine output FIFOs and the single result sink of the accelerator.

## Interface
- OUTW, 24: data width per beat.
- NREQ, 4: number of requesters; legal range 2..16.
- BURST, 8: maximum beats per grant; legal range 1..256.
- IDW (localparam) = $clog2(NREQ); CNTW (localparam) = $clog2(BURST+1).

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- IN_AXIS_TDATA  in  NREQ*OUTW  packed data; requester i occupies bits [i*OUTW +: OUTW].
- IN_AXIS_TVALID  in  NREQ  per-requester valid.
- IN_AXIS_TREADY  out  NREQ  per-requester ready (combinational).
- OUT_AXIS_TDATA  out  OUTW  registered output data.
- OUT_AXIS_TID  out  IDW  registered index of the requester that sourced the beat.
- OUT_AXIS_TVALID  out  1  registered output valid.
- OUT_AXIS_TREADY  in  1  sink ready.
- BUSY  out  1  high while in state GRANT.

## Operation
- Reset (reset=0, async): state=IDLE, grant=0, last_grant=NREQ-1, beat_cnt=0. OUT_AXIS_TDATA=0, OUT_AXIS_TID=0, OUT_AXIS_TVALID=0, BUSY=0, IN_AXIS_TREADY=0.
- Output stage ready: stage_rdy = !OUT_AXIS_TVALID || OUT_AXIS_TREADY. A stalled stage holds TDATA and TID stable.
- State IDLE: IN_AXIS_TREADY=0. If any TVALID bit is high, the winner is the first valid index searching upward from last_grant+1, mod NREQ. Next state is GRANT with grant=winner and beat_cnt=0.
- State GRANT: IN_AXIS_TREADY[grant]=stage_rdy; all other TREADY bits are 0.
- Accepted beat (TVALID[grant] && TREADY[grant]): the output stage loads the beat's data, TID=grant, TVALID=1, and beat_cnt increments.
- An output beat leaves when OUT_AXIS_TVALID && OUT_AXIS_TREADY. If no new beat loads in that cycle, TVALID clears.
- GRANT goes to IDLE, with last_grant=grant and beat_cnt=0, when either holds:
  - a beat is accepted and beat_cnt==BURST-1 (burst complete), or
  - TVALID[grant]==0 while stage_rdy==1 (early release; empty FIFO).
- GRANT holds the grant indefinitely while stage_rdy==0 (sink backpressure). A dropped TVALID does not cause release during this stall.
- Non-granted requesters are never acknowledged. Their data is never sampled.

## Timing
- Arbitration latency: a requester that asserts TVALID in IDLE at cycle 0 is granted at cycle 1. Its first beat is accepted at the end of cycle 1 and visible at OUT at cycle 2.
- Throughput within a burst: 1 beat/clk while the sink is ready.
- Bubble between bursts: exactly 1 cycle (the IDLE arbitration cycle). Sustained efficiency is BURST/(BURST+1).
- Output stage: single register with no skid buffer. Ready passes combinationally from OUT_AXIS_TREADY to IN_AXIS_TREADY.
- beat_cnt never exceeds BURST-1.
- last_grant wraps NREQ-1 -> 0.
- Reset asserted mid-burst: outputs drop to their reset values immediately. Any beat held in the output register is lost. The first grant after reset goes to requester 0 if it is valid.

## Configuration
- CONV_ARB_FIXED_PRIO_EN defined: fixed priority. The IDLE winner is the lowest valid index and last_grant is ignored. Burst limit and early release are unchanged.
- CONV_ARB_FIXED_PRIO_EN not defined (default): round-robin as described above.

## Test plan
1. NREQ=4, BURST=8, only req 2 valid with 8 beats 0x000001..0x000008, sink always ready -> BUSY rises at cycle 1; OUT emits 8 beats in order on consecutive cycles from cycle 2, TID=2; then IDLE.
2. Req 0 and req 1 continuously valid, BURST=4 -> OUT TID sequence 0,0,0,0,1,1,1,1,0,... with one bubble cycle between groups.
3. Req 3 granted, OUT_AXIS_TREADY held low 5 cycles after the first beat -> OUT_AXIS_TDATA/TID stable, IN_AXIS_TREADY[3]=0 during the stall, no beat lost or duplicated, burst resumes.
4. Req 1 supplies 3 beats then drops TVALID, BURST=8, req 2 valid -> release after 3 beats; next grant is req 2 after one IDLE cycle.
5. With CONV_ARB_FIXED_PRIO_EN, req 0 and req 3 always valid, BURST=2 -> TID is always 0; req 3 is never granted.
6. reset pulsed low mid-burst (beat 4 of 8, req 1) -> OUT_AXIS_TVALID=0 and BUSY=0 asynchronously; after release with req 0 and 1 valid, the first grant is to req 0.
